// File: rtl/ext_stage_if.sv
// Decode-to-execute handshake bundle for the immediate-extension stage.
// The master side is decode/execute; the slave side is ext_stage.
interface ext_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ExtOp;
    logic [DATA_W-1:0] instr_in;
    logic [DATA_W-1:0] pc_plus4;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] Ext_num;
    logic              ext_illegal;
    logic [CNT_W-1:0]  illegal_cnt;

    modport master (
        output in_valid, ExtOp, instr_in, pc_plus4, flush, out_ready,
        input  in_ready, out_valid, Ext_num, ext_illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, ExtOp, instr_in, pc_plus4, flush, out_ready,
        output in_ready, out_valid, Ext_num, ext_illegal, illegal_cnt
    );
endinterface

// File: rtl/ext_stage.sv
// Registered immediate extender between decode and execute: zero/sign/LUI,
// jump-region and branch-target modes, one-entry valid/ready register with flush.
module ext_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int INDEX_W = 26,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    ext_stage_if.slave bus
);
    localparam logic [2:0] OP_ZEXT   = 3'd0;
    localparam logic [2:0] OP_SEXT   = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_LUI    = 3'd3;
    localparam logic [2:0] OP_BRANCH = 3'd4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [IMM_W-1:0]         imm;
    logic [INDEX_W-1:0]       idx;
    logic signed [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0]        hi_mask;
    logic [DATA_W-1:0]        res;
    logic                     res_ill;

    always_comb begin
        imm     = bus.instr_in[IMM_W-1:0];
        idx     = bus.instr_in[INDEX_W-1:0];
        imm_sx  = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
        // Keeps the PC bits above the jump index; empty when the index fills the word.
        hi_mask = ~((DATA_W'(1) << (INDEX_W + 2)) - DATA_W'(1));
        res     = '0;
        res_ill = 1'b0;
        case (bus.ExtOp)
            OP_ZEXT:   res = DATA_W'(imm);
            OP_SEXT:   res = $unsigned(imm_sx);
            OP_JUMP:   res = (bus.pc_plus4 & hi_mask) | (DATA_W'(idx) << 2);
            OP_LUI:    res = DATA_W'(imm) << (DATA_W - IMM_W);
            OP_BRANCH: res = bus.pc_plus4 + $unsigned(imm_sx <<< 2);
            default:   res_ill = 1'b1;
        endcase
    end

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] ext_num_q, ext_num_d;
    logic              ext_illegal_q, ext_illegal_d;
    logic [CNT_W-1:0]  illegal_cnt_q, illegal_cnt_d;
    logic              in_ready;
    logic              accept;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready && !bus.flush;

    always_comb begin
        out_valid_d   = out_valid_q;
        ext_num_d     = ext_num_q;
        ext_illegal_d = ext_illegal_q;
        illegal_cnt_d = illegal_cnt_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d   = 1'b1;
            ext_num_d     = res;
            ext_illegal_d = res_ill;
            if (res_ill) begin
                illegal_cnt_d = sat_inc(illegal_cnt_q);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Pipeline register boundary: decode-side beat becomes execute-side operand.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            ext_num_q     <= '0;
            ext_illegal_q <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            ext_num_q     <= ext_num_d;
            ext_illegal_q <= ext_illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.Ext_num     = ext_num_q;
    assign bus.ext_illegal = ext_illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;
endmodule

// File: tb/tb_ext_stage.sv
// Scoreboard bench for ext_stage: directed beats push expectations, a negedge
// monitor pops and compares each beat as execute consumes it.
module tb_ext_stage;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ill;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb[$];
    logic [CNT_W-1:0] cnt_model;

    ext_stage_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    ext_stage #(.DATA_W(DATA_W), .IMM_W(16), .INDEX_W(26), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got Ext_num=%h ill=%b, required no beat", bus.Ext_num, bus.ext_illegal);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.Ext_num !== e.data || bus.ext_illegal !== e.ill || bus.illegal_cnt !== e.cnt) begin
                    errors++;
                    $display("FAIL beat: got Ext_num=%h ill=%b cnt=%0d, required Ext_num=%h ill=%b cnt=%0d",
                             bus.Ext_num, bus.ext_illegal, bus.illegal_cnt, e.data, e.ill, e.cnt);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Present one beat, wait (bounded) for in_ready, log its expectation, let it be accepted.
    task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] instr,
                        input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] exp_data);
        int n;
        exp_t e;
        bus.in_valid = 1'b1;
        bus.ExtOp    = op;
        bus.instr_in = instr;
        bus.pc_plus4 = pc;
        @(negedge clk);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0, required 1");
        end else begin
            if (op > 3'd4) cnt_model = (&cnt_model) ? cnt_model : cnt_model + CNT_W'(1);
            e.data = exp_data;
            e.ill  = (op > 3'd4);
            e.cnt  = cnt_model;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cnt_model     = '0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.ExtOp     = 3'd0;
        bus.instr_in  = '0;
        bus.pc_plus4  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_ext_num", bus.Ext_num, 32'd0);
        chk("rst_ext_illegal", 32'(bus.ext_illegal), 32'd0);
        chk("rst_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Extension modes, back to back at full throughput
        send(3'd1, 32'h0000_8001, 32'h0, 32'hFFFF_8001);
        send(3'd0, 32'h0000_8001, 32'h0, 32'h0000_8001);
        send(3'd2, 32'h0012_3456, 32'hA000_0004, 32'hA048_D158);
        send(3'd3, 32'h0000_1234, 32'h0, 32'h1234_0000);
        send(3'd4, 32'h0000_FFFE, 32'h0000_0004, 32'hFFFF_FFFC);
        send(3'd4, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0004);
        idle(2);

        // Back-pressure: A held for 3 cycles while B waits
        send(3'd3, 32'h0000_ABCD, 32'h0, 32'hABCD_0000);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.ExtOp     = 3'd0;
        bus.instr_in  = 32'h0000_5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_ext_num", bus.Ext_num, 32'hABCD_0000);
            @(posedge clk);
        end
        #1;
        bus.out_ready = 1'b1;
        send(3'd0, 32'h0000_5555, 32'h0, 32'h0000_5555);
        idle(2);

        // Flush with an illegal beat while a beat is held
        bus.out_ready = 1'b0;
        send(3'd1, 32'h0000_0001, 32'h0, 32'h0000_0001);
        bus.in_valid = 1'b1;
        bus.ExtOp    = 3'd6;
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;

        // Saturating illegal counter
        for (int i = 0; i < 5; i++) send(3'd7, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0);
        idle(2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_ext_num", bus.Ext_num, 32'd0);
        chk("rst2_ext_illegal", 32'(bus.ext_illegal), 32'd0);
        chk("rst2_illegal_cnt", 32'(bus.illegal_cnt), 32'd0);
        reset = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
